// File: rtl/transport_packetizer.sv
// ----------------------------------------------------------------------------
// transport_packetizer
//
// Transmit-side transport layer for the telephony link. Control words and
// audio samples are framed into addressed packets, queued, and serialized one
// byte at a time towards the link layer.
//
// Packet on the wire (first byte first):
//   header   : [7:6] type (00 control, 01 audio), [5:0] payload length
//   dest     : phone number taken from the address book at commit time
//   payload  : words in arrival order, MSB byte of each word first
//   checksum : XOR of every preceding byte of the packet
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ab_we/ab_idx/ab_num address-book write port
//   dest_idx            address-book entry used as destination at commit
//   cmd_valid/cmd_data/cmd_ready   control word input handshake
//   aud_valid/aud_data/aud_ready   audio word input handshake
//   out_byte/out_valid/out_ready   serialized byte output handshake
//   pkt_count           packets queued, including the one being sent
// ----------------------------------------------------------------------------
module transport_packetizer #(
    parameter int DATA_W      = 16,
    parameter int AUDIO_WORDS = 4,
    parameter int QUEUE_DEPTH = 8,
    parameter int AB_ENTRIES  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ab_we,
    input  logic [$clog2(AB_ENTRIES)-1:0]  ab_idx,
    input  logic [7:0]                     ab_num,
    input  logic [$clog2(AB_ENTRIES)-1:0]  dest_idx,
    input  logic                           cmd_valid,
    input  logic [DATA_W-1:0]              cmd_data,
    output logic                           cmd_ready,
    input  logic                           aud_valid,
    input  logic [DATA_W-1:0]              aud_data,
    output logic                           aud_ready,
    output logic [7:0]                     out_byte,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(QUEUE_DEPTH):0]   pkt_count
);

    localparam int Q_W   = $clog2(QUEUE_DEPTH);
    localparam int PAY_W = AUDIO_WORDS * DATA_W;
    localparam int CNT_W = (AUDIO_WORDS > 1) ? $clog2(AUDIO_WORDS) : 1;

    localparam logic [5:0]     CMD_LEN   = 6'(DATA_W / 8);
    localparam logic [5:0]     AUD_LEN   = 6'(PAY_W / 8);
    localparam logic [Q_W:0]   CNT_FULL  = (Q_W + 1)'(QUEUE_DEPTH);
    localparam logic [Q_W:0]   CNT_ONE   = (Q_W + 1)'(1);
    localparam logic [CNT_W-1:0] ASM_LAST = CNT_W'(AUDIO_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DEST,
        S_PAY,
        S_CSUM
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]        ab_mem     [AB_ENTRIES];
    logic              q_type_mem [QUEUE_DEPTH];
    logic [7:0]        q_dest_mem [QUEUE_DEPTH];
    logic [PAY_W-1:0]  q_pay_mem  [QUEUE_DEPTH];
    logic [DATA_W-1:0] asm_mem    [AUDIO_WORDS];

    logic [Q_W-1:0]    head_reg, tail_reg;
    logic [Q_W:0]      count_reg;
    logic [CNT_W-1:0]  asm_cnt_reg;
    logic              audio_pending_reg;

    // Head entry as seen by the serializer (registered read of the queue)
    logic              ent_type_reg;
    logic [7:0]        ent_dest_reg;
    logic [PAY_W-1:0]  ent_pay_reg;

    state_t            state_reg, state_next;
    logic [7:0]        csum_reg;
    logic [5:0]        pay_left_reg;

    // ------------------------------------------------------------------
    // Input side
    // ------------------------------------------------------------------
    logic              full;
    logic              cmd_fire, aud_fire, aud_commit, commit;
    logic              hs, pop, load;
    logic [Q_W-1:0]    rd_addr;
    logic [7:0]        commit_dest;
    logic [PAY_W-1:0]  commit_pay;
    logic [PAY_W-1:0]  asm_flat;

    // Flatten the assembly buffer so word 0 lands in the most significant
    // slot, which is the first payload word on the wire.
    generate
        for (genvar gi = 0; gi < AUDIO_WORDS; gi++) begin : g_asm_flat
            assign asm_flat[PAY_W-1-gi*DATA_W -: DATA_W] = asm_mem[gi];
        end
    endgenerate

    assign full       = (count_reg == CNT_FULL);
    assign cmd_ready  = !full;
    assign aud_ready  = !audio_pending_reg;
    assign cmd_fire   = cmd_valid && !full;
    assign aud_fire   = aud_valid && !audio_pending_reg;
    // Control wins the single commit slot; a pending audio packet waits.
    assign aud_commit = audio_pending_reg && !cmd_fire && !full;
    assign commit     = cmd_fire || aud_commit;

    // Address book is read before this cycle's write takes effect.
    assign commit_dest = ab_mem[dest_idx];
    // Control payload is left-aligned so the serializer always starts at
    // the top of the payload field regardless of packet type.
    assign commit_pay  = cmd_fire ? (PAY_W'(cmd_data) << (PAY_W - DATA_W)) : asm_flat;

    // ------------------------------------------------------------------
    // Serializer handshakes
    // ------------------------------------------------------------------
    assign hs   = out_valid && out_ready;
    assign pop  = (state_reg == S_CSUM) && hs;
    // Load the head entry when leaving IDLE, or chain straight into the next
    // packet after the checksum byte when more than the current one is queued.
    assign load = ((state_reg == S_IDLE) && (count_reg != '0)) ||
                  (pop && (count_reg > CNT_ONE));
    assign rd_addr = pop ? (head_reg + Q_W'(1)) : head_reg;

    // ------------------------------------------------------------------
    // Control state with reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < AB_ENTRIES; i++) begin
                ab_mem[i] <= '0;
            end
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            asm_cnt_reg       <= '0;
            audio_pending_reg <= 1'b0;
        end else begin
            if (ab_we) begin
                ab_mem[ab_idx] <= ab_num;
            end

            if (aud_fire) begin
                if (asm_cnt_reg == ASM_LAST) begin
                    asm_cnt_reg       <= '0;
                    audio_pending_reg <= 1'b1;
                end else begin
                    asm_cnt_reg <= asm_cnt_reg + CNT_W'(1);
                end
            end
            if (aud_commit) begin
                audio_pending_reg <= 1'b0;
            end

            if (commit) begin
                tail_reg <= tail_reg + Q_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + Q_W'(1);
            end
            case ({commit, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM-style storage: queue entries, assembly buffer, registered read
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit) begin
            q_type_mem[tail_reg] <= !cmd_fire;
            q_dest_mem[tail_reg] <= commit_dest;
            q_pay_mem[tail_reg]  <= commit_pay;
        end
        if (aud_fire) begin
            asm_mem[asm_cnt_reg] <= aud_data;
        end
        if (load) begin
            ent_type_reg <= q_type_mem[rd_addr];
            ent_dest_reg <= q_dest_mem[rd_addr];
            ent_pay_reg  <= q_pay_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Serializer FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (count_reg != '0) state_next = S_HDR;
            S_HDR:  if (hs) state_next = S_DEST;
            S_DEST: if (hs) state_next = S_PAY;
            S_PAY:  if (hs && (pay_left_reg == 6'd1)) state_next = S_CSUM;
            S_CSUM: if (hs) state_next = (count_reg > CNT_ONE) ? S_HDR : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Payload byte selection: pay_left counts down, so the offset from the
    // start of the payload is length minus what remains.
    logic [5:0]  ent_len;
    logic [5:0]  pay_off;
    logic [15:0] pay_shamt;
    logic [7:0]  pay_byte;

    assign ent_len   = ent_type_reg ? AUD_LEN : CMD_LEN;
    assign pay_off   = ent_len - pay_left_reg;
    assign pay_shamt = 16'(PAY_W - 8) - {7'd0, pay_off, 3'b000};
    assign pay_byte  = 8'(ent_pay_reg >> pay_shamt);

    // Serializer FSM: outputs
    always_comb begin
        out_valid = (state_reg != S_IDLE);
        out_byte  = 8'h00;
        case (state_reg)
            S_HDR:   out_byte = {1'b0, ent_type_reg, ent_len};
            S_DEST:  out_byte = ent_dest_reg;
            S_PAY:   out_byte = pay_byte;
            S_CSUM:  out_byte = csum_reg;
            default: out_byte = 8'h00;
        endcase
    end

    // Checksum and payload down-counter; both only move on a handshake so the
    // presented byte stays put under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_reg     <= '0;
            pay_left_reg <= '0;
        end else if (load) begin
            csum_reg     <= '0;
            pay_left_reg <= '0;
        end else if (hs) begin
            if (state_reg != S_CSUM) begin
                csum_reg <= csum_reg ^ out_byte;
            end
            if (state_reg == S_DEST) begin
                pay_left_reg <= ent_len;
            end else if (state_reg == S_PAY) begin
                pay_left_reg <= pay_left_reg - 6'd1;
            end
        end
    end

    assign pkt_count = count_reg;

endmodule
